// File: rtl/count_checker_pkg.sv
// count_checker_pkg: state type and shared constants for count_checker.
// Optional feature macro used by the top: COUNT_CHECKER_SYNC_EN.
package count_checker_pkg;

  typedef enum logic [0:0] {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } state_e;

  localparam int LOCK_COUNT_DEF = 4;

  // good_run width; covers LOCK_COUNT up to 15
  localparam int RUN_W = 4;

  // Pipeline depth from count_in to the sample register s
  function automatic int sample_depth(input bit sync_en);
    return sync_en ? 3 : 1;
  endfunction

endpackage

// File: rtl/count_checker_sync.sv
// count_sync: W-bit two-flop resynchronizer, async reset to 0.
// BYPASS=1 passes d_i straight through for clk-synchronous sources.
module count_sync #(
  parameter int W      = 8,
  parameter bit BYPASS = 1'b0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  if (BYPASS) begin : g_bypass
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst_n;
    assign q_o = d_i;
  end else begin : g_sync
    logic [W-1:0] meta_q;
    logic [W-1:0] sync_q;

    // Two-stage capture of the asynchronous count bus
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        meta_q <= '0;
        sync_q <= '0;
      end else begin
        meta_q <= d_i;
        sync_q <= meta_q;
      end
    end

    assign q_o = sync_q;
  end

endmodule

// File: rtl/count_checker.sv
// count_checker: watches a free-running counter for +1 sequencing.
// Define COUNT_CHECKER_SYNC_EN to resynchronize count_in (latency 4).
module count_checker
  import count_checker_pkg::*;
#(
  parameter int W          = 8,
  parameter int LOCK_COUNT = LOCK_COUNT_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] count_in,
  input  logic         clr,
  output logic         locked,
  output logic         err_pulse,
  output logic         err_flag,
  output logic [W-1:0] err_cnt,
  output logic [W-1:0] last_val
);

`ifdef COUNT_CHECKER_SYNC_EN
  localparam bit SYNC_EN = 1'b1;
`else
  localparam bit SYNC_EN = 1'b0;
`endif

  localparam int VLD_D = sample_depth(SYNC_EN);
  localparam logic [RUN_W-1:0] RUN_LAST =
    RUN_W'(LOCK_COUNT - 1);

  logic [W-1:0]     cin_w;
  logic [W-1:0]     s_q;
  logic [VLD_D-1:0] vld_q;
  logic             s_vld;

  state_e           state_q, state_d;
  logic [RUN_W-1:0] run_q, run_d;
  logic [W-1:0]     prev_q, prev_d;
  logic             pv_q, pv_d;
  logic             locked_q, locked_d;
  logic             pulse_q, pulse_d;
  logic             flag_q, flag_d;
  logic [W-1:0]     cnt_q, cnt_d;
  logic [W-1:0]     last_q, last_d;

  logic             first_w;
  logic             good_w;
  logic             bad_w;

  count_sync #(
    .W      (W),
    .BYPASS (!SYNC_EN)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (count_in),
    .q_o   (cin_w)
  );

  // Sample register; vld_q marks when real data reaches s
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q   <= '0;
      vld_q <= '0;
    end else begin
      s_q   <= cin_w;
      vld_q <= (vld_q << 1) | VLD_D'(1);
    end
  end

  assign s_vld = vld_q[VLD_D-1];

  assign first_w = s_vld && !pv_q;
  assign good_w  = s_vld && pv_q && (s_q != prev_q)
                && (s_q == prev_q + W'(1));
  assign bad_w   = s_vld && pv_q && (s_q != prev_q)
                && (s_q != prev_q + W'(1));

  // Next-state: classify the sample, then apply clr last
  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    prev_d  = prev_q;
    pv_d    = pv_q;
    last_d  = last_q;
    pulse_d = 1'b0;
    flag_d  = flag_q;
    cnt_d   = cnt_q;

    unique case (1'b1)
      first_w: begin
        pv_d   = 1'b1;
        prev_d = s_q;
        last_d = s_q;
      end
      good_w: begin
        prev_d = s_q;
        last_d = s_q;
        if (state_q == SEARCH) begin
          run_d = run_q + RUN_W'(1);
          if (run_q == RUN_LAST) begin
            state_d = LOCKED;
          end
        end
      end
      bad_w: begin
        prev_d = s_q;
        last_d = s_q;
        run_d  = '0;
        if (state_q == LOCKED) begin
          state_d = SEARCH;
          pulse_d = 1'b1;
          flag_d  = 1'b1;
          if (cnt_q != {W{1'b1}}) begin
            cnt_d = cnt_q + W'(1);
          end
        end
      end
      default: begin
      end
    endcase

    if (clr) begin
      flag_d = 1'b0;
      cnt_d  = '0;
    end
  end

  assign locked_d = (state_d == LOCKED);

  // Checker state and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= SEARCH;
      run_q    <= '0;
      prev_q   <= '0;
      pv_q     <= 1'b0;
      locked_q <= 1'b0;
      pulse_q  <= 1'b0;
      flag_q   <= 1'b0;
      cnt_q    <= '0;
      last_q   <= '0;
    end else begin
      state_q  <= state_d;
      run_q    <= run_d;
      prev_q   <= prev_d;
      pv_q     <= pv_d;
      locked_q <= locked_d;
      pulse_q  <= pulse_d;
      flag_q   <= flag_d;
      cnt_q    <= cnt_d;
      last_q   <= last_d;
    end
  end

  assign locked    = locked_q;
  assign err_pulse = pulse_q;
  assign err_flag  = flag_q;
  assign err_cnt   = cnt_q;
  assign last_val  = last_q;

endmodule

// File: tb/tb_count_checker.sv
// tb_count_checker: random and directed checks of count_checker
// against a value-sequence reference model.
module tb_count_checker;

  localparam int W  = 8;
  localparam int LC = 4;
`ifdef COUNT_CHECKER_SYNC_EN
  localparam int D = 3;
`else
  localparam int D = 1;
`endif
  localparam int MAXC = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         clr = 1'b0;
  logic [W-1:0] count_in = '0;
  logic         locked;
  logic         err_pulse;
  logic         err_flag;
  logic [W-1:0] err_cnt;
  logic [W-1:0] last_val;

  int errors = 0;
  int checks = 0;

  count_checker #(.W(W), .LOCK_COUNT(LC)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .count_in (count_in),
    .clr      (clr),
    .locked   (locked),
    .err_pulse(err_pulse),
    .err_flag (err_flag),
    .err_cnt  (err_cnt),
    .last_val (last_val)
  );

  always #5 clk = ~clk;

  // Reference model: values seen by the checker, in order
  logic [W-1:0] pipe[$];
  bit           m_have;
  bit           m_locked;
  bit           m_pulse;
  bit           m_flag;
  int           m_run;
  int           m_cnt;
  int           m_prev;
  int           m_last;

  task automatic model_reset();
    pipe.delete();
    m_have = 0; m_locked = 0; m_pulse = 0; m_flag = 0;
    m_run = 0; m_cnt = 0; m_prev = 0; m_last = 0;
  endtask

  task automatic model_step(input logic [W-1:0] v, input bit c);
    int s;
    m_pulse = 0;
    pipe.push_back(v);
    if (pipe.size() > D) begin
      s = int'(pipe.pop_front());
      if (!m_have) begin
        m_have = 1; m_prev = s; m_last = s;
      end else if (s != m_prev) begin
        if (s == (m_prev + 1) % (MAXC + 1)) begin
          if (!m_locked) begin
            m_run++;
            if (m_run >= LC) m_locked = 1;
          end
        end else begin
          m_run = 0;
          if (m_locked) begin
            m_locked = 0;
            m_pulse = 1;
            m_flag = 1;
            if (m_cnt < MAXC) m_cnt++;
          end
        end
        m_prev = s; m_last = s;
      end
    end
    if (c) begin
      m_cnt = 0; m_flag = 0;
    end
  endtask

  function automatic logic [2*W+2:0] exp_v();
    return {m_locked, m_pulse, m_flag, W'(m_cnt), W'(m_last)};
  endfunction

  function automatic logic [2*W+2:0] dut_v();
    return {locked, err_pulse, err_flag, err_cnt, last_val};
  endfunction

  // One clock: drive at negedge, model at posedge, back to negedge
  task automatic cyc(input logic [W-1:0] v, input bit c);
    count_in = v;
    clr = c;
    @(posedge clk);
    model_step(v, c);
    @(negedge clk);
  endtask

  task automatic test_reset();
    model_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (dut_v() !== exp_v())
      $display("FAIL reset got=%h want=%h", dut_v(), exp_v());
    if (dut_v() !== exp_v()) errors++;
    rst_n = 1'b1;
  endtask

  task automatic test_lock();
    int v;
    for (int i = 0; i < 5 + D + 1; i++) begin
      v = (i < 5) ? i : 4;
      cyc(W'(v), 1'b0);
      checks++;
      if (dut_v() !== exp_v()) begin
        errors++;
        $display("FAIL lock i=%0d got=%h want=%h", i, dut_v(), exp_v());
      end
    end
    checks++;
    if (locked !== 1'b1 || err_cnt !== '0) begin
      errors++;
      $display("FAIL lock_final locked=%b cnt=%0d want 1/0",
               locked, err_cnt);
    end
  endtask

  task automatic test_wrap();
    logic [W-1:0] v;
    for (int i = 0; i < 5 + D; i++) begin
      v = (i < 5) ? W'(8'hF9 + i) : W'(8'hFD);
      cyc(v, 1'b0);
      checks++;
      if (dut_v() !== exp_v()) begin
        errors++;
        $display("FAIL wrap_pre i=%0d got=%h want=%h",
                 i, dut_v(), exp_v());
      end
    end
    for (int i = 0; i < 4 + D + 1; i++) begin
      v = (i < 4) ? W'(8'hFE + i) : W'(8'h01);
      cyc(v, 1'b0);
      checks++;
      if (dut_v() !== exp_v() || err_pulse !== 1'b0
          || locked !== 1'b1) begin
        errors++;
        $display("FAIL wrap i=%0d got=%h want=%h lock=%b pulse=%b",
                 i, dut_v(), exp_v(), locked, err_pulse);
      end
    end
  endtask

  task automatic test_jump();
    int pulses = 0;
    for (int i = 0; i < 6 + D; i++)
      cyc((i < 6) ? W'(8'h0B + i) : W'(8'h10), 1'b0);
    cyc(8'h10, 1'b1);
    for (int i = 0; i < D + 3; i++) begin
      cyc(8'h20, 1'b0);
      if (err_pulse === 1'b1) pulses++;
      checks++;
      if (dut_v() !== exp_v()) begin
        errors++;
        $display("FAIL jump i=%0d got=%h want=%h",
                 i, dut_v(), exp_v());
      end
    end
    checks++;
    if (pulses != 1 || err_flag !== 1'b1 || err_cnt !== 8'd1
        || locked !== 1'b0 || last_val !== 8'h20) begin
      errors++;
      $display("FAIL jump_final pulses=%0d flag=%b cnt=%0d lock=%b last=%h want 1/1/1/0/20",
               pulses, err_flag, err_cnt, locked, last_val);
    end
  endtask

  task automatic test_saturate();
    int b = 8'h30;
    int prev_cnt = 0;
    int bad = 0;
    for (int it = 0; it < 300; it++) begin
      for (int k = 0; k < 6; k++) begin
        cyc(W'((b + k) % (MAXC + 1)), 1'b0);
        if (dut_v() !== exp_v() || int'(err_cnt) < prev_cnt) bad++;
        prev_cnt = int'(err_cnt);
      end
      b = (b + 7 + int'($urandom_range(0, 200))) % (MAXC + 1);
    end
    for (int k = 0; k < D + 1; k++) begin
      cyc(W'(b), 1'b0);
      if (dut_v() !== exp_v() || int'(err_cnt) < prev_cnt) bad++;
      prev_cnt = int'(err_cnt);
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL sat_track bad_cycles=%0d want 0", bad);
    end
    checks++;
    if (err_cnt !== 8'hFF) begin
      errors++;
      $display("FAIL sat_final cnt=%h want ff", err_cnt);
    end
  endtask

  task automatic test_clr_error();
    for (int i = 0; i < 5 + D + 1; i++)
      cyc((i < 5) ? W'(8'h40 + i) : W'(8'h44), 1'b0);
    checks++;
    if (locked !== 1'b1 || dut_v() !== exp_v()) begin
      errors++;
      $display("FAIL clr_pre lock=%b got=%h want=%h",
               locked, dut_v(), exp_v());
    end
    for (int i = 0; i < D; i++) cyc(8'h90, 1'b0);
    cyc(8'h90, 1'b1);
    checks++;
    if (err_pulse !== 1'b1 || err_cnt !== '0 || err_flag !== 1'b0
        || locked !== 1'b0) begin
      errors++;
      $display("FAIL clr_err pulse=%b cnt=%0d flag=%b lock=%b want 1/0/0/0",
               err_pulse, err_cnt, err_flag, locked);
    end
  endtask

  task automatic test_random();
    int v = int'(last_val);
    int r;
    int bad = 0;
    bit c;
    for (int i = 0; i < 600; i++) begin
      r = int'($urandom_range(0, 99));
      c = 1'b0;
      if (r < 65) v = (v + 1) % (MAXC + 1);
      else if (r < 80) v = int'($urandom_range(0, MAXC));
      else if (r < 95) v = v;
      else c = 1'b1;
      cyc(W'(v), c);
      if (dut_v() !== exp_v()) begin
        bad++;
        if (bad <= 5)
          $display("FAIL random i=%0d got=%h want=%h",
                   i, dut_v(), exp_v());
      end
    end
    checks++;
    if (bad != 0) errors++;
  endtask

  task automatic test_reset_mid();
    int pulses = 0;
    for (int i = 0; i < 5 + D + 1; i++)
      cyc((i < 5) ? W'(8'h50 + i) : W'(8'h54), 1'b0);
    cyc(8'h20, 1'b0);
    for (int i = 0; i < 5 + D + 1; i++)
      cyc((i < 5) ? W'(8'h60 + i) : W'(8'h64), 1'b0);
    checks++;
    if (locked !== 1'b1 || err_cnt === '0) begin
      errors++;
      $display("FAIL rst_pre lock=%b cnt=%0d want 1/nonzero",
               locked, err_cnt);
    end
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (locked !== 1'b0 || err_cnt !== '0 || dut_v() !== exp_v()) begin
      errors++;
      $display("FAIL rst_async got=%h want=%h", dut_v(), exp_v());
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < D + 3; i++) begin
      cyc((i < 1) ? W'(8'h77) : W'(8'h78), 1'b0);
      if (err_pulse === 1'b1) pulses++;
      checks++;
      if (dut_v() !== exp_v()) begin
        errors++;
        $display("FAIL rst_after i=%0d got=%h want=%h",
                 i, dut_v(), exp_v());
      end
    end
    checks++;
    if (pulses != 0 || err_flag !== 1'b0 || last_val !== 8'h78) begin
      errors++;
      $display("FAIL rst_first pulses=%0d flag=%b last=%h want 0/0/78",
               pulses, err_flag, last_val);
    end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_wrap();
    test_jump();
    test_saturate();
    test_clr_error();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
